mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the shared memory port.
// The master modport is the arbiter's view; slave is the pipeline/memory side.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_stall;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
        output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
        input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory, one transaction
// in flight at a time; data wins unless fetch has been starved for MAXBURST grants.
module mem_arbiter #(
    parameter int unsigned LAT      = 2,
    parameter int unsigned MAXBURST = 4
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arbiter_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0] LatCnt   = 3'(LAT);
    localparam logic [3:0] MaxBurst = 4'(MAXBURST);

    logic [1:0]  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic        gnt_if_q, gnt_if_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        pick_if;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        wcnt_d     = wcnt_q;
        gnt_if_d   = gnt_if_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        pick_if = bus.if_req && (!bus.dm_req || (starve_q == MaxBurst));

        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d  = ISSUE;
                    gnt_if_d = pick_if;
                    if (pick_if) begin
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        wdata_d  = 32'd0;
                        be_d     = 4'hF;
                        starve_d = 4'd0;
                    end else begin
                        we_d    = bus.dm_we;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                        be_d    = bus.dm_be;
                        // Only a data grant that actually bypasses a waiting fetch counts.
                        if (!bus.if_req) begin
                            starve_d = 4'd0;
                        end else if (starve_q != MaxBurst) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    wcnt_d  = LatCnt;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q - 3'd1;
                if (wcnt_q == 3'd1) begin
                    state_d = DONE;
                    if (gnt_if_q) begin
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            wcnt_q     <= 3'd0;
            gnt_if_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wcnt_q     <= wcnt_d;
            gnt_if_q   <= gnt_if_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    logic if_ack, dm_ack;

    always_comb begin
        if_ack = (state_q == DONE) && gnt_if_q;
        dm_ack = (state_q == DONE) && !gnt_if_q;
    end

    assign bus.if_ack    = if_ack;
    assign bus.dm_ack    = dm_ack;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    // Stalls are gated by rstn so every output is quiet while reset is held.
    assign bus.if_stall  = rstn && bus.if_req && !if_ack;
    assign bus.dm_stall  = rstn && bus.dm_req && !dm_ack;
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level timing model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mem_arbiter;

    localparam int LAT  = 2;
    localparam int MAXB = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .LAT      (LAT),
        .MAXBURST (MAXB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment memory; unwritten words read back as a function of their address.
    logic [31:0] mem   [int unsigned];
    logic [31:0] sched [int];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] be);
        logic [31:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[a[31:2]] = w;
    endfunction

    // Read data appears only in the cycle exactly LAT after the command; junk otherwise.
    always @(posedge clk) begin
        #1;
        bus.mem_rdata = sched.exists(cyc) ? sched[cyc] : (32'hE000_0000 | 32'(cyc));
    end

    // Model: one transaction at a time, timed by issue/ack cycle numbers.
    int          iss_c = -10;
    int          ack_c = -10;
    int          starve = 0;
    bit          m_if;
    bit          m_we;
    logic [31:0] m_addr, m_wdata, m_cap;
    logic [3:0]  m_be;
    logic [31:0] m_ifr = 0;
    logic [31:0] m_dmr = 0;
    byte         order_q[$];
    int          en_cyc_q[$];
    int          en_cnt = 0;
    int          dm_ack_cnt = 0;
    int          dm_ack_cyc = -1;

    always @(negedge clk) begin
        bit exp_en, exp_ifa, exp_dma, f;
        if (!rstn) begin
            iss_c = -10; ack_c = -10; starve = 0; m_ifr = 0; m_dmr = 0;
            sched.delete();
            chk("rst_mem_en", 32'(bus.mem_en), 0);
            chk("rst_acks", 32'({bus.if_ack, bus.dm_ack}), 0);
            chk("rst_stalls", 32'({bus.if_stall, bus.dm_stall}), 0);
            chk("rst_rdata", bus.if_rdata | bus.dm_rdata, 0);
            chk("rst_mem_bus", bus.mem_addr | bus.mem_wdata | 32'({bus.mem_be, bus.mem_we}), 0);
        end else begin
            if (bus.mem_en) begin
                en_cnt++;
                en_cyc_q.push_back(cyc);
                if (bus.mem_we) mem_wr(bus.mem_addr, bus.mem_wdata, bus.mem_be);
                else sched[cyc + LAT] = mem_rd(bus.mem_addr);
            end
            if (bus.dm_ack) begin
                dm_ack_cnt++;
                dm_ack_cyc = cyc;
            end

            exp_en  = (cyc == iss_c);
            exp_ifa = (cyc == ack_c) && m_if;
            exp_dma = (cyc == ack_c) && !m_if;
            if (cyc == ack_c && !m_we) begin
                if (m_if) m_ifr = m_cap;
                else m_dmr = m_cap;
            end

            chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
            if (exp_en) begin
                chk("mem_we", 32'(bus.mem_we), 32'(m_we));
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_be", 32'(bus.mem_be), 32'(m_be));
                if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            chk("if_ack", 32'(bus.if_ack), 32'(exp_ifa));
            chk("dm_ack", 32'(bus.dm_ack), 32'(exp_dma));
            chk("if_rdata", bus.if_rdata, m_ifr);
            chk("dm_rdata", bus.dm_rdata, m_dmr);
            chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req && !exp_ifa));
            chk("dm_stall", 32'(bus.dm_stall), 32'(bus.dm_req && !exp_dma));

            // Grant decision for the edge closing this cycle (only when not busy).
            if (cyc > ack_c && (bus.if_req || bus.dm_req)) begin
                f = bus.if_req && (!bus.dm_req || starve == MAXB);
                m_if = f;
                if (f) begin
                    starve = 0;
                    m_we = 1'b0; m_addr = bus.if_addr; m_be = 4'hF; m_wdata = 0;
                end else begin
                    starve = bus.if_req ? ((starve < MAXB) ? starve + 1 : MAXB) : 0;
                    m_we = bus.dm_we; m_addr = bus.dm_addr;
                    m_be = bus.dm_be; m_wdata = bus.dm_wdata;
                end
                m_cap = mem_rd(m_addr);
                iss_c = cyc + 1;
                ack_c = cyc + 1 + (m_we ? 1 : LAT + 1);
                order_q.push_back(f ? 8'h46 : 8'h44);
            end
        end
    end

    task automatic drive_dm(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        bit got = 0;
        @(posedge clk); #1;
        bus.dm_we = we; bus.dm_addr = a; bus.dm_wdata = d; bus.dm_be = be; bus.dm_req = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.dm_ack) got = 1;
        end
        chk("dm_ack_seen", 32'(got), 1);
    endtask

    task automatic drive_if(input logic [31:0] a);
        bit got = 0;
        @(posedge clk); #1;
        bus.if_addr = a; bus.if_req = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.if_ack) got = 1;
        end
        chk("if_ack_seen", 32'(got), 1);
    endtask

    // Fetch with literal timing checks relative to the cycle the request is raised.
    task automatic timed_fetch(input logic [31:0] a, input logic [31:0] exp,
                               input string tag, input bit now);
        int t0;
        int en_c = -1;
        int ak_c = -1;
        logic [31:0] rd = 0;
        logic st = 1;
        if (!now) begin
            @(posedge clk); #1;
        end
        bus.if_addr = a; bus.if_req = 1'b1; t0 = cyc;
        for (int i = 0; i < 20 && ak_c < 0; i++) begin
            @(negedge clk);
            if (bus.mem_en && en_c < 0) en_c = cyc;
            if (bus.if_ack) begin
                ak_c = cyc; rd = bus.if_rdata; st = bus.if_stall;
            end
        end
        chk({tag, "_issue_cyc"}, 32'(en_c - t0), 1);
        chk({tag, "_ack_cyc"}, 32'(ak_c - t0), 32'(LAT + 2));
        chk({tag, "_rdata"}, rd, exp);
        chk({tag, "_stall_at_ack"}, 32'(st), 0);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    initial begin
        int t0, a0, e0;
        string exp_s;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
        bus.mem_rdata = 0;
        mem[32'h10 >> 2] = 32'h0050_0093;
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single fetch.
        timed_fetch(32'h10, 32'h0050_0093, "fetch", 1'b0);

        // Single write.
        @(posedge clk); #1;
        bus.dm_we = 1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'hDEAD_BEEF;
        bus.dm_be = 4'b0011; bus.dm_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("wr_mem_en", 32'(bus.mem_en), 1);
        chk("wr_mem_we", 32'(bus.mem_we), 1);
        chk("wr_mem_addr", bus.mem_addr, 32'h80);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("wr_mem_be", 32'(bus.mem_be), 32'h3);
        @(negedge clk);
        chk("wr_dm_ack", 32'(bus.dm_ack), 1);
        chk("wr_if_ack", 32'(bus.if_ack), 0);
        @(posedge clk); #1;
        bus.dm_req = 0; bus.dm_we = 0;

        // Simultaneous requests: data read first, fetch two cycles after the data ack.
        order_q.delete(); en_cyc_q.delete();
        fork
            begin drive_dm(1'b0, 32'h80, 32'h0, 4'h0); @(posedge clk); #1 bus.dm_req = 0; end
            begin drive_if(32'h44); @(posedge clk); #1 bus.if_req = 0; end
        join
        chk("sim_issues", 32'(en_cyc_q.size()), 2);
        chk("sim_grants", 32'(order_q.size()), 2);
        if (order_q.size() == 2) begin
            chk("sim_first", 32'(order_q[0]), 32'h44);
            chk("sim_second", 32'(order_q[1]), 32'h46);
        end
        if (en_cyc_q.size() == 2) chk("sim_fetch_gap", 32'(en_cyc_q[1] - dm_ack_cyc), 2);
        chk("sim_dm_rdata", bus.dm_rdata, 32'hA5A5_BEEF);
        chk("sim_if_rdata", bus.if_rdata, 32'hA5A5_0044);

        // Starvation: six back-to-back data reads against a held fetch.
        order_q.delete();
        fork
            begin drive_if(32'h48); @(posedge clk); #1 bus.if_req = 0; end
            begin
                for (int k = 0; k < 6; k++) drive_dm(1'b0, 32'h100 + 32'(4 * k), 0, 0);
                @(posedge clk); #1 bus.dm_req = 0;
            end
        join
        exp_s = "DDDDFDD";
        chk("starve_grants", 32'(order_q.size()), 7);
        for (int k = 0; k < 7 && k < order_q.size(); k++)
            chk($sformatf("starve_order_%0d", k), 32'(order_q[k]), 32'(exp_s[k]));

        // Byte-enable merge through the write path, then read back.
        drive_dm(1'b1, 32'h200, 32'h1122_3344, 4'hF);
        drive_dm(1'b1, 32'h200, 32'hAABB_CCDD, 4'b0100);
        drive_dm(1'b0, 32'h200, 32'h0, 4'h0);
        @(posedge clk); #1 bus.dm_req = 0;
        chk("be_merge_rdata", bus.dm_rdata, 32'h11BB_3344);

        // Reset while a fetch sits in WAIT.
        @(posedge clk); #1 bus.if_addr = 32'h20; bus.if_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1 rstn = 1'b0;
        #1;
        chk("rstw_if_ack", 32'(bus.if_ack), 0);
        chk("rstw_mem_en", 32'(bus.mem_en), 0);
        chk("rstw_dm_rdata", bus.dm_rdata, 0);
        chk("rstw_if_stall", 32'(bus.if_stall), 0);
        bus.if_req = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        timed_fetch(32'h24, 32'hA5A5_0024, "post_rst", 1'b1);

        // Data request dropped during WAIT still completes exactly once.
        a0 = dm_ack_cnt; e0 = en_cnt;
        @(posedge clk); #1 bus.dm_we = 0; bus.dm_addr = 32'h84; bus.dm_req = 1; t0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.dm_req = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("drop_acks", 32'(dm_ack_cnt - a0), 1);
        chk("drop_issues", 32'(en_cnt - e0), 1);
        chk("drop_rdata", bus.dm_rdata, 32'hA5A5_0084);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
